// File: rtl/arb_pkg.sv
// Shared definitions for the memory-port arbiter: state encoding, requester
// indices and hold-counter width.
package arb_pkg;

  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_GRANT = 1'b1;

  localparam int REQ_IFETCH = 0;
  localparam int REQ_LSU    = 1;
  localparam int REQ_DBG    = 2;
  localparam int REQ_SPARE  = 3;

  localparam int HOLD_W = 8;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request bit scanning cyclically
// upward from ptr.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] w_cand;

  // Scan from the farthest candidate back to ptr so the closest hit wins.
  always_comb begin
    valid  = |req;
    idx    = ptr;
    w_cand = ptr;
    for (int i = 3; i >= 0; i--) begin
      w_cand = ptr + 2'(i);
      if (req[w_cand]) idx = w_cand;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Four-requester round-robin arbiter owning the shared-port mux select.
// Optional forced release after TIMEOUT_CYCLES when ARB_TIMEOUT_EN is defined.
//
// state     | meaning
// ARB_IDLE  | no grant held; arbitrate among pending requests
// ARB_GRANT | grant held until done, abort or (optionally) timeout
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int RST_PTR        = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       start
`ifdef ARB_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);

  if (NREQ != 4) begin : g_bad_nreq
    $error("mem_port_arbiter: NREQ must be 4");
  end
  if (RST_PTR < 0 || RST_PTR > 3) begin : g_bad_rst_ptr
    $error("mem_port_arbiter: RST_PTR must be 0..3");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be 2..255");
  end

  localparam logic [1:0] LP_RST_PTR = 2'(RST_PTR);

  logic       r_state;
  logic [3:0] r_grant;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic       r_busy;
  logic       r_start;

  logic       w_valid;
  logic [1:0] w_idx;
  logic       w_abort;
  logic       w_limit;
  logic       w_release;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  assign w_abort   = ~req[r_sel];
  assign w_release = done | w_abort | w_limit;

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] r_hold;
  logic              r_timeout;

  assign w_limit = (r_hold == HOLD_W'(TIMEOUT_CYCLES - 1));

  // Held at zero while idle so every grant starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == ARB_IDLE) begin
        r_hold <= '0;
      end else begin
        if (r_hold != '1) r_hold <= r_hold + 1'b1;
        if (w_limit && !done && !w_abort) r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_limit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= LP_RST_PTR;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (r_state == ARB_IDLE) begin
        if (w_valid) begin
          r_state <= ARB_GRANT;
          r_grant <= onehot4(w_idx);
          r_sel   <= w_idx;
          r_busy  <= 1'b1;
          r_start <= 1'b1;
        end
      end else if (w_release) begin
        // sel is left at the last owner; only grant/busy drop.
        r_state <= ARB_IDLE;
        r_grant <= '0;
        r_busy  <= 1'b0;
        r_ptr   <= r_sel + 2'd1;
      end
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;
  assign start = r_start;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; stimulus queues expected grants and
// releases, a monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       start;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NREQ           (4),
    .RST_PTR        (0),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .done  (done),
    .grant (grant),
    .sel   (sel),
    .busy  (busy),
    .start (start)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  typedef struct packed {
    logic [1:0] s;
    logic       to;
  } rel_t;

  int         n_pass   = 0;
  int         n_checks = 0;
  logic [1:0] gq[$];
  rel_t       rq[$];
  logic       prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [1:0] e;
    rel_t       r;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_busy = 1'b0;
        continue;
      end
      chk("inv_onehot", 32'($onehot0(grant)), 1);
      chk("inv_busy_grant", busy, 32'(grant != 4'b0000));
      if (busy) chk("inv_sel_grant", grant, 4'b0001 << sel);
      if (start) begin
        if (gq.size() == 0) fail("unexpected_grant");
        else begin
          e = gq.pop_front();
          chk("grant_sel", sel, e);
          chk("grant_vec", grant, 4'b0001 << e);
        end
      end
      if (prev_busy && !busy) begin
        if (rq.size() == 0) fail("unexpected_release");
        else begin
          r = rq.pop_front();
          chk("rel_sel_kept", sel, r.s);
`ifdef ARB_TIMEOUT_EN
          chk("rel_timeout", timeout, r.to);
`endif
        end
      end
`ifdef ARB_TIMEOUT_EN
      else chk("no_spurious_timeout", timeout, 0);
`endif
      prev_busy = busy;
    end
  end

  // Called on a falling edge; returns on the falling edge after release.
  task automatic run_txn(input logic [3:0] r, input logic [1:0] exp, input int dur);
    req = r;
    gq.push_back(exp);
    @(negedge clk);
    chk("lat_busy", busy, 1);
    chk("lat_start", start, 1);
    @(negedge clk);
    chk("start_once", start, 0);
    repeat (dur - 2) @(negedge clk);
    done = 1'b1;
    rq.push_back(rel_t'{s: exp, to: 1'b0});
    @(negedge clk);
    done = 1'b0;
    chk("rel_busy", busy, 0);
    chk("rel_grant", grant, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Single requester 1, then 0101 must go to 2 (pointer now 2).
    run_txn(4'b0010, 2'd1, 3);
    run_txn(4'b0101, 2'd2, 3);

    // Fresh reset, all requesting: 0,1,2,3,0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) run_txn(4'b1111, 2'(k), 3);

    // Abort by granted requester 2 (pointer 1, only bit 2 set).
    req = 4'b0100;
    gq.push_back(2'd2);
    @(negedge clk);
    chk("abort_busy", busy, 1);
    @(negedge clk);
    req = 4'b0000;
    rq.push_back(rel_t'{s: 2'd2, to: 1'b0});
    @(negedge clk);
    chk("abort_rel_busy", busy, 0);
    chk("abort_sel_kept", sel, 2);
    run_txn(4'b1101, 2'd3, 3);

    // done while idle: no grant, no pointer change (pointer 0 -> picks 1).
    req  = 4'b0000;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_start", start, 0);
    run_txn(4'b1010, 2'd1, 3);

    // Async reset mid-grant: pointer 2 picks 3, reset restores pointer 0.
    req = 4'b1010;
    gq.push_back(2'd3);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_sel", sel, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(4'b1010, 2'd1, 3);

`ifdef ARB_TIMEOUT_EN
    // Pointer 2, only requester 0: forced release after 4 grant cycles.
    req = 4'b0001;
    gq.push_back(2'd0);
    rq.push_back(rel_t'{s: 2'd0, to: 1'b1});
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    chk("to_len", cnt, 4);
    chk("to_pulse", timeout, 1);
    req = 4'b0000;
    @(negedge clk);
    chk("to_one_cycle", timeout, 0);

    // done on the limit cycle: normal release, no timeout pulse.
    req = 4'b0001;
    gq.push_back(2'd0);
    @(negedge clk);
    chk("to2_busy", busy, 1);
    repeat (3) @(negedge clk);
    done = 1'b1;
    rq.push_back(rel_t'{s: 2'd0, to: 1'b0});
    @(negedge clk);
    done = 1'b0;
    chk("to2_busy_rel", busy, 0);
    chk("to2_no_timeout", timeout, 0);
    req = 4'b0000;
`else
    // Without timeout a grant is held indefinitely.
    req = 4'b0001;
    gq.push_back(2'd0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("hold_len", cnt, 20);
    chk("hold_grant", grant, 4'b0001);
    done = 1'b1;
    rq.push_back(rel_t'{s: 2'd0, to: 1'b0});
    @(negedge clk);
    done = 1'b0;
    chk("hold_rel_busy", busy, 0);
    req = 4'b0000;
`endif

    repeat (3) @(negedge clk);
    chk("grant_q_empty", gq.size(), 0);
    chk("rel_q_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
